rotary_led_ring: RTL and testbench



---
 rtl/rotary_pkg.sv | 25 ++
 rtl/input_debounce.sv | 51 +++++
 rtl/rotary_led_ring.sv | 129 ++++++++++++
 tb/tb_rotary_led_ring.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared mode encodings and reload helper for the rotary LED ring.
package rotary_pkg;

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BAR    = 2'b01;
  localparam logic [1:0] MODE_BINARY = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // LED pattern loaded when the display mode changes. The value is carried
  // in 32 bits (the widest legal ring) and narrowed by the caller; HOLD keeps
  // whatever is currently shown.
  function automatic logic [31:0] reload_value(input logic [1:0]  mode,
                                               input logic [31:0] cur);
    logic [31:0] val;
    case (mode)
      MODE_ROTATE: val = 32'd1;
      MODE_BAR:    val = 32'd0;
      MODE_BINARY: val = 32'd0;
      MODE_HOLD:   val = cur;
      default:     val = cur;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stability filter for one raw encoder
// contact. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// clocks of disagreement with the currently accepted level.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             db_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous contact into the clk domain; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive cycles of disagreement; the cycle that completes the
  // run commits the new level, so the accepted level moves exactly
  // DEBOUNCE_CYCLES clocks after the synchronised input first differs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_r  <= 1'b1;
      cnt_r <= '0;
    end else if (sync2_r == db_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      db_r  <= sync2_r;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign dout = db_r;

endmodule

// File: rtl/rotary_led_ring.sv
// Rotary encoder to LED ring driver: debounces the raw A/B contacts, decodes a
// step on each accepted A rise (direction from B) and applies it to the LED
// bank according to the selected display mode.
module rotary_led_ring
  import rotary_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rot_a,
  input  logic             rot_b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             evt,
  output logic             evt_cw
);

  logic             db_a_s;
  logic             db_b_s;
  logic             db_a_prev_r;
  logic             step_s;
  logic             step_cw_s;
  logic             reload_s;
  logic [1:0]       mode_q_r;
  logic [WIDTH-1:0] led_r;
  logic [WIDTH-1:0] led_next_s;
  logic             evt_r;
  logic             evt_cw_r;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk  (clk),
    .rst  (rst),
    .din  (rot_a),
    .dout (db_a_s)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk  (clk),
    .rst  (rst),
    .din  (rot_b),
    .dout (db_b_s)
  );

  // Remember the previous accepted A level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_a_prev_r <= 1'b1;
    end else begin
      db_a_prev_r <= db_a_s;
    end
  end

  assign step_s    = db_a_s & ~db_a_prev_r;
  assign step_cw_s = ~db_b_s;
  assign reload_s  = (mode != mode_q_r);

  // Next LED pattern: a mode change reloads and takes priority over a step.
  always_comb begin
    led_next_s = led_r;
    if (reload_s) begin
      led_next_s = WIDTH'(reload_value(mode, 32'(led_r)));
    end else if (step_s) begin
      case (mode_q_r)
        MODE_ROTATE: begin
          if (step_cw_s) begin
            led_next_s = {led_r[WIDTH-2:0], led_r[WIDTH-1]};
          end else begin
            led_next_s = {led_r[0], led_r[WIDTH-1:1]};
          end
        end
        MODE_BAR: begin
          if (step_cw_s) begin
            led_next_s = {led_r[WIDTH-2:0], 1'b1};
          end else begin
            led_next_s = {1'b0, led_r[WIDTH-1:1]};
          end
        end
        MODE_BINARY: begin
          if (step_cw_s) begin
            led_next_s = led_r + WIDTH'(1);
          end else begin
            led_next_s = led_r - WIDTH'(1);
          end
        end
        MODE_HOLD: begin
          led_next_s = led_r;
        end
        default: begin
          led_next_s = led_r;
        end
      endcase
    end else begin
      led_next_s = led_r;
    end
  end

  // Display state: mode tracker and LED bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q_r <= MODE_ROTATE;
      led_r    <= WIDTH'(1);
    end else begin
      mode_q_r <= mode;
      led_r    <= led_next_s;
    end
  end

  // Step reporting runs in every mode, even when the LED ignores the step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_r    <= 1'b0;
      evt_cw_r <= 1'b1;
    end else begin
      evt_r <= step_s;
      if (step_s) begin
        evt_cw_r <= step_cw_s;
      end else begin
        evt_cw_r <= evt_cw_r;
      end
    end
  end

  assign led    = led_r;
  assign evt    = evt_r;
  assign evt_cw = evt_cw_r;

endmodule

// File: tb/tb_rotary_led_ring.sv
// Directed bench for rotary_led_ring at WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_rotary_led_ring;

  logic       clk;
  logic       rst;
  logic       rot_a;
  logic       rot_b;
  logic [1:0] mode;
  logic [7:0] led;
  logic       evt;
  logic       evt_cw;

  int passed = 0;
  int total  = 0;
  int evt_count = 0;
  int evt_snap;

  rotary_led_ring #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rot_a  (rot_a),
    .rot_b  (rot_b),
    .mode   (mode),
    .led    (led),
    .evt    (evt),
    .evt_cw (evt_cw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally evt pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (evt === 1'b1) evt_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full detent: set direction, drop A, raise A, then verify the exact
  // 7-edge latency of the evt pulse and its reported direction.
  task automatic do_step(input string tag, input logic cw);
    rot_b = ~cw;
    repeat (8) tick();
    rot_a = 1'b0;
    repeat (8) tick();
    rot_a = 1'b1;
    repeat (6) tick();
    check({tag, "_early"}, {31'd0, evt}, 32'd0);
    tick();
    check({tag, "_evt"}, {31'd0, evt}, 32'd1);
    check({tag, "_dir"}, {31'd0, evt_cw}, {31'd0, cw});
    tick();
  endtask

  initial begin
    rst = 1'b1; rot_a = 1'b1; rot_b = 1'b1; mode = 2'b00;
    repeat (3) tick();
    check("rst_led", {24'd0, led}, 32'h01);
    check("rst_evt", {31'd0, evt}, 32'd0);
    check("rst_cw", {31'd0, evt_cw}, 32'd1);
    rst = 1'b0;
    repeat (12) tick();
    check("release_noevt", evt_count, 32'd0);
    check("release_led", {24'd0, led}, 32'h01);

    // 1: first CW step with exact latency check
    rot_b = 1'b0;
    repeat (8) tick();
    rot_a = 1'b0;
    repeat (8) tick();
    rot_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_quiet", {31'd0, evt}, 32'd0);
    end
    tick();
    check("lat_evt", {31'd0, evt}, 32'd1);
    check("lat_led", {24'd0, led}, 32'h02);
    check("lat_cw", {31'd0, evt_cw}, 32'd1);
    tick();
    check("lat_pulse1", {31'd0, evt}, 32'd0);

    // 2: ROTATE wrap both ways
    for (int i = 0; i < 7; i++) do_step("rot_cw", 1'b1);
    check("rot_wrap", {24'd0, led}, 32'h01);
    do_step("rot_ccw", 1'b0);
    check("rot_ccw_led", {24'd0, led}, 32'h80);

    // 3: glitches
    evt_snap = evt_count;
    rot_a = 1'b0;
    repeat (3) tick();
    rot_a = 1'b1;
    repeat (14) tick();
    check("glitch3_evt", evt_count, evt_snap);
    check("glitch3_led", {24'd0, led}, 32'h80);
    rot_a = 1'b0;
    repeat (4) tick();
    rot_a = 1'b1;
    repeat (4) tick();
    repeat (12) tick();
    check("glitch4_evt", evt_count, evt_snap + 1);
    check("glitch4_led", {24'd0, led}, 32'h40);

    // 4: BAR fill and drain with saturation
    mode = 2'b01;
    tick();
    check("bar_reload", {24'd0, led}, 32'h00);
    for (int i = 0; i < 9; i++) do_step("bar_cw", 1'b1);
    check("bar_full", {24'd0, led}, 32'hFF);
    for (int i = 0; i < 10; i++) do_step("bar_ccw", 1'b0);
    check("bar_empty", {24'd0, led}, 32'h00);

    // 5: BINARY, coincident reload, HOLD
    mode = 2'b10;
    tick();
    check("bin_reload", {24'd0, led}, 32'h00);
    do_step("bin_ccw", 1'b0);
    check("bin_under", {24'd0, led}, 32'hFF);
    mode = 2'b00;
    tick();
    check("rot_reload", {24'd0, led}, 32'h01);
    rot_b = 1'b0;
    repeat (8) tick();
    rot_a = 1'b0;
    repeat (8) tick();
    rot_a = 1'b1;
    repeat (6) tick();
    mode = 2'b10;
    tick();
    check("coinc_led", {24'd0, led}, 32'h00);
    check("coinc_evt", {31'd0, evt}, 32'd1);
    check("coinc_cw", {31'd0, evt_cw}, 32'd1);
    do_step("bin_cw", 1'b1);
    check("bin_inc", {24'd0, led}, 32'h01);
    mode = 2'b11;
    tick();
    check("hold_reload", {24'd0, led}, 32'h01);
    do_step("hold_cw", 1'b1);
    do_step("hold_ccw", 1'b0);
    check("hold_led", {24'd0, led}, 32'h01);

    // 6: reset mid-debounce
    mode = 2'b00;
    tick();
    do_step("pre_rst", 1'b0);
    check("pre_rst_led", {24'd0, led}, 32'h80);
    rot_a = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_led", {24'd0, led}, 32'h01);
    check("mid_rst_evt", {31'd0, evt}, 32'd0);
    check("mid_rst_cw", {31'd0, evt_cw}, 32'd1);
    rot_a = 1'b1;
    repeat (3) tick();
    evt_snap = evt_count;
    rst = 1'b0;
    repeat (15) tick();
    check("post_rst_noevt", evt_count, evt_snap);
    check("post_rst_led", {24'd0, led}, 32'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
